// File: rtl/axis_frame_gather_pkg.sv
// Shared constants for the frame gatherer: frame geometry and read-FSM encodings.
package axis_frame_gather_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 4064;
    localparam int unsigned IN_WIDTH_DEF    = 256;
    localparam int unsigned WORDS_PER_FRAME = (DATA_WIDTH_DEF + IN_WIDTH_DEF - 1) / IN_WIDTH_DEF;
    localparam int unsigned WIDX_W          = $clog2(WORDS_PER_FRAME);

    localparam logic [0:0] R_IDLE    = 1'b0;
    localparam logic [0:0] R_PRESENT = 1'b1;

    // Width actually kept for word k once the frame is truncated to DATA_WIDTH.
    function automatic int unsigned word_bits(int unsigned dw, int unsigned iw, int unsigned k);
        return ((dw - k * iw) < iw) ? (dw - k * iw) : iw;
    endfunction

endpackage

// File: rtl/axis_frame_gather_slot.sv
// One frame buffer: word-indexed writes, and writing word 0 zeroes every other word.
module frame_slot
    import axis_frame_gather_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned IN_WIDTH   = IN_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [WIDX_W-1:0]     i_widx,
    input  logic [IN_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0] o_data
);

    for (genvar k = 0; k < WORDS_PER_FRAME; k++) begin : g_word
        localparam int unsigned LO = k * IN_WIDTH;
        localparam int unsigned W  = word_bits(DATA_WIDTH, IN_WIDTH, k);

        logic [W-1:0] r_word;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_word <= '0;
            end else if (i_we) begin
                if (i_widx == WIDX_W'(k)) begin
                    r_word <= i_wdata[W-1:0];
                end else if (i_widx == '0) begin
                    r_word <= '0;
                end
            end
        end

        assign o_data[LO +: W] = r_word;
    end

endmodule

// File: rtl/axis_frame_gather.sv
// Gathers narrow core words into wide frames in a two-slot ping-pong buffer for the C2H packer.
module axis_frame_gather
    import axis_frame_gather_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned IN_WIDTH   = IN_WIDTH_DEF
) (
    input  logic                  m_axis_c2h_aclk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    input  logic                  data_next,
    output logic [15:0]           frame_cnt,
    output logic [1:0]            slots_full
);

    logic [1:0]        r_slots_full;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [WIDX_W-1:0] r_word_cnt;
    logic [0:0]        r_state;
    logic              r_data_next_q;
    logic [15:0]       r_frame_cnt;
    logic              r_run;

    logic                  w_accept;
    logic                  w_close;
    logic                  w_take;
    logic                  w_other_full;
    logic [1:0]            w_we;
    logic [1:0]            w_slots_full_d;
    logic [DATA_WIDTH-1:0] w_slot_data [2];

    // r_run keeps in_ready low until the first clock after reset release.
    assign in_ready     = r_run && !r_slots_full[r_wr_ptr];
    assign w_accept     = in_valid && in_ready;
    assign w_close      = w_accept && (in_last || r_word_cnt == WIDX_W'(WORDS_PER_FRAME - 1));
    assign w_take       = (r_state == R_PRESENT) && r_data_next_q && !data_next;
    // A slot closing on the same edge as a take counts, so data_valid never drops between frames.
    assign w_other_full = r_slots_full[~r_rd_ptr] || (w_close && (r_wr_ptr != r_rd_ptr));
    assign w_we[0]      = w_accept && !r_wr_ptr;
    assign w_we[1]      = w_accept && r_wr_ptr;

    for (genvar s = 0; s < 2; s++) begin : g_slot
        frame_slot #(
            .DATA_WIDTH (DATA_WIDTH),
            .IN_WIDTH   (IN_WIDTH)
        ) u_slot (
            .i_clk   (m_axis_c2h_aclk),
            .i_rst   (rst),
            .i_we    (w_we[s]),
            .i_widx  (r_word_cnt),
            .i_wdata (in_data),
            .o_data  (w_slot_data[s])
        );
    end

    always_comb begin
        w_slots_full_d = r_slots_full;
        if (w_close) w_slots_full_d[r_wr_ptr] = 1'b1;
        if (w_take)  w_slots_full_d[r_rd_ptr] = 1'b0;
    end

    always_ff @(posedge m_axis_c2h_aclk or posedge rst) begin
        if (rst) begin
            r_run         <= 1'b0;
            r_slots_full  <= '0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_word_cnt    <= '0;
            r_state       <= R_IDLE;
            r_data_next_q <= 1'b1;
            r_frame_cnt   <= '0;
        end else begin
            r_run         <= 1'b1;
            r_data_next_q <= data_next;
            r_slots_full  <= w_slots_full_d;
            if (w_accept) begin
                r_word_cnt <= w_close ? '0 : r_word_cnt + WIDX_W'(1);
            end
            if (w_close) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            case (r_state)
                R_IDLE: begin
                    if (r_slots_full[r_rd_ptr]) r_state <= R_PRESENT;
                end
                R_PRESENT: begin
                    if (w_take) begin
                        r_rd_ptr    <= ~r_rd_ptr;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= w_other_full ? R_PRESENT : R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign data       = r_rd_ptr ? w_slot_data[1] : w_slot_data[0];
    assign data_valid = (r_state == R_PRESENT);
    assign frame_cnt  = r_frame_cnt;
    assign slots_full = r_slots_full;

endmodule

// File: tb/tb_axis_frame_gather.sv
// Directed and randomized checks of axis_frame_gather against a frame-queue reference model.
module tb_axis_frame_gather;

    localparam int DW = 4064;
    localparam int IW = 256;
    localparam int NW = 16;

    typedef logic [IW-1:0] word_t;
    typedef logic [DW-1:0] frame_t;

    logic        clk = 1'b0;
    logic        rst;
    word_t       in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    frame_t      data;
    logic        data_valid;
    logic        data_next;
    logic [15:0] frame_cnt;
    logic [1:0]  slots_full;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    frame_t exp_q[$];

    always #5 clk = ~clk;

    axis_frame_gather dut (
        .m_axis_c2h_aclk (clk),
        .rst             (rst),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_last         (in_last),
        .data            (data),
        .data_valid      (data_valid),
        .data_next       (data_next),
        .frame_cnt       (frame_cnt),
        .slots_full      (slots_full)
    );

    // Expected frame: words packed low-first, anything past the sent words is zero.
    function automatic frame_t build(input word_t w[NW], input int n);
        logic [NW*IW-1:0] t;
        t = '0;
        for (int k = 0; k < n; k++) t[k*IW +: IW] = w[k];
        return t[DW-1:0];
    endfunction

    function automatic word_t rand_word();
        word_t r;
        for (int i = 0; i < IW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input frame_t obs, input frame_t exp);
        logic [NW*IW-1:0] po;
        logic [NW*IW-1:0] pe;
        int bad;
        po = '0;
        pe = '0;
        po[DW-1:0] = obs;
        pe[DW-1:0] = exp;
        bad = 0;
        for (int k = NW - 1; k >= 0; k--) if (po[k*IW +: IW] !== pe[k*IW +: IW]) bad = k;
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: word %0d got %0h expected %0h", tag, bad,
                   po[bad*IW +: IW], pe[bad*IW +: IW]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input word_t w, input logic last);
        int waits;
        in_data  = w;
        in_last  = last;
        in_valid = 1'b1;
        waits    = 0;
        while (!in_ready && waits < 200) begin
            tick();
            waits++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input word_t w[NW], input int n);
        for (int k = 0; k < n; k++) send_word(w[k], (k == n - 1) && (n < NW));
    endtask

    task automatic wait_valid(input string tag);
        int waits;
        waits = 0;
        while (!data_valid && waits < 20) begin
            tick();
            waits++;
        end
        chk(tag, 32'(data_valid), 32'd1);
    endtask

    task automatic take();
        data_next = 1'b0;
        tick();
        exp_cnt++;
    endtask

    word_t  w[NW];
    frame_t f_p;
    frame_t f_q;
    frame_t f_r;
    int     len;

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        data_next = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_slots", 32'(slots_full), 32'd0);
        repeat (2) tick();
        chk("rst_held_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single full frame with word k = {8{k}}.
        for (int k = 0; k < NW; k++) w[k] = {8{32'(k)}};
        send_frame(w, NW);
        chk("full_valid_early", 32'(data_valid), 32'd0);
        chk("full_slots", 32'(slots_full), 32'b01);
        tick();
        chk("full_valid", 32'(data_valid), 32'd1);
        chk_frame("full_data", data, build(w, NW));
        chk("full_top_word", data[DW-1 -: 32], 32'd15);

        take();
        chk("handoff_valid", 32'(data_valid), 32'd0);
        chk("handoff_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("handoff_slots", 32'(slots_full), 32'b00);
        data_next = 1'b1;
        tick();

        // Early close after 3 words.
        for (int k = 0; k < NW; k++) w[k] = rand_word();
        send_frame(w, 3);
        wait_valid("early_valid");
        chk_frame("early_data", data, build(w, 3));
        take();
        chk("early_cnt", 32'(frame_cnt), 32'(exp_cnt));
        data_next = 1'b1;
        tick();

        // Back-pressure: two full frames with no take.
        for (int k = 0; k < NW; k++) w[k] = rand_word();
        f_p = build(w, NW);
        send_frame(w, NW);
        for (int k = 0; k < NW; k++) w[k] = rand_word();
        f_q = build(w, NW);
        send_frame(w, NW);
        chk("bp_slots", 32'(slots_full), 32'b11);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < NW; k++) w[k] = rand_word();
        f_r = build(w, NW);
        in_data  = w[0];
        in_valid = 1'b1;
        repeat (3) tick();
        chk("bp_stall_ready", 32'(in_ready), 32'd0);
        chk("bp_stall_slots", 32'(slots_full), 32'b11);
        chk_frame("bp_first_data", data, f_p);
        take();
        chk("bp_switch_valid", 32'(data_valid), 32'd1);
        chk_frame("bp_second_data", data, f_q);
        chk("bp_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("bp_ready_after_take", 32'(in_ready), 32'd1);
        data_next = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_33rd_slots", 32'(slots_full), 32'b10);

        // Close the new frame on the same edge as the take of the presented one.
        for (int k = 1; k < NW - 1; k++) send_word(w[k], 1'b0);
        in_data   = w[NW-1];
        in_valid  = 1'b1;
        data_next = 1'b0;
        chk("sim_ready", 32'(in_ready), 32'd1);
        tick();
        exp_cnt++;
        in_valid  = 1'b0;
        data_next = 1'b1;
        chk("sim_valid", 32'(data_valid), 32'd1);
        chk_frame("sim_data", data, f_r);
        chk("sim_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("sim_slots", 32'(slots_full), 32'b01);
        tick();
        take();
        chk("sim_drain_valid", 32'(data_valid), 32'd0);
        chk("sim_drain_cnt", 32'(frame_cnt), 32'(exp_cnt));
        data_next = 1'b1;
        tick();

        // Randomized frames against the queue model.
        for (int it = 0; it < 24; it++) begin
            if (exp_q.size() == 0 || (exp_q.size() < 2 && $urandom_range(0, 1) == 1)) begin
                len = $urandom_range(1, NW);
                for (int k = 0; k < NW; k++) w[k] = rand_word();
                exp_q.push_back(build(w, len));
                send_frame(w, len);
            end else begin
                wait_valid("rand_valid");
                chk_frame("rand_data", data, exp_q.pop_front());
                take();
                chk("rand_cnt", 32'(frame_cnt), 32'(exp_cnt));
                chk("rand_valid_after_take", 32'(data_valid), 32'(exp_q.size() != 0));
                data_next = 1'b1;
                tick();
            end
        end
        while (exp_q.size() != 0) begin
            wait_valid("drain_valid");
            chk_frame("drain_data", data, exp_q.pop_front());
            take();
            chk("drain_cnt", 32'(frame_cnt), 32'(exp_cnt));
            data_next = 1'b1;
            tick();
        end

        // Async reset while one frame is presented and another is 7 words in.
        for (int k = 0; k < NW; k++) w[k] = rand_word();
        send_frame(w, NW);
        wait_valid("pre_rst_valid");
        for (int k = 0; k < 7; k++) send_word(rand_word(), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(data_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_slots", 32'(slots_full), 32'd0);
        chk("arst_cnt", 32'(frame_cnt), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        exp_cnt = 0;
        tick();
        chk("arst_release_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < NW; k++) w[k] = rand_word();
        send_frame(w, NW);
        wait_valid("arst_new_valid");
        chk_frame("arst_new_data", data, build(w, NW));
        chk("arst_new_cnt0", 32'(frame_cnt), 32'd0);
        take();
        chk("arst_new_cnt1", 32'(frame_cnt), 32'(exp_cnt));
        data_next = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
